// File: rtl/tpu_pkg.sv
// Shared types and constants for the tpumac systolic array datapath.
package tpu_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned DIM_DEF     = 8;

  typedef logic signed [BITS_AB_DEF-1:0] ab_t;
  typedef ab_t ab_row_t [DIM_DEF];

  localparam int unsigned CNT_MAX = 2 * DIM_DEF - 1;

  // Shift count at which every element of a freshly loaded matrix has left the buffer.
  function automatic int unsigned cnt_max(int unsigned dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/skew_row.sv
// One row of the A skew buffer: a DIM+DELAY slot shift register with zero-padded
// parallel load; slot 0 is the registered output.
module skew_row #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned DELAY   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      shift,
  input  logic signed [BITS_AB-1:0] din [DIM],
  output logic signed [BITS_AB-1:0] dout
);

  localparam int Dim   = int'(DIM);
  localparam int Delay = int'(DELAY);
  localparam int Slots = Dim + Delay;

  logic signed [BITS_AB-1:0] slot_q [Slots];
  logic signed [BITS_AB-1:0] slot_d [Slots];

  always_comb begin
    for (int s = 0; s < Slots; s++) slot_d[s] = slot_q[s];
    if (load) begin
      // Leading DELAY slots stay zero so the row lags row 0 by DELAY cycles.
      for (int s = 0; s < Slots; s++) slot_d[s] = '0;
      for (int c = 0; c < Dim; c++) slot_d[Delay + c] = din[c];
    end else if (shift) begin
      for (int s = 0; s < Slots - 1; s++) slot_d[s] = slot_q[s + 1];
      slot_d[Slots - 1] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < Slots; s++) slot_q[s] <= '0;
    end else begin
      for (int s = 0; s < Slots; s++) slot_q[s] <= slot_d[s];
    end
  end

  assign dout = slot_q[0];

endmodule

// File: rtl/a_skew_buffer.sv
// A operand staging buffer: rows are loaded one per cycle and streamed out with
// row r delayed r cycles, forming the diagonal wavefront for the systolic array.
module a_skew_buffer
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned DIM     = DIM_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     Arow,
  input  logic signed [BITS_AB-1:0]  Ain  [DIM],
  output logic signed [BITS_AB-1:0]  Aout [DIM],
  output logic                       drained
);

  localparam int unsigned AW     = $clog2(DIM);
  localparam int unsigned CntMax = cnt_max(DIM);
  localparam int unsigned CW     = $clog2(CntMax + 1);

  logic [DIM-1:0] row_load;
  logic           load_any;
  logic           do_shift;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Equality decode so an out-of-range Arow selects no row and leaves cnt alone.
  always_comb begin
    row_load = '0;
    for (int r = 0; r < int'(DIM); r++) row_load[r] = WrEn && (Arow == AW'(r));
  end

  assign load_any = |row_load;
  assign do_shift = en && !load_any;

  always_comb begin
    cnt_d = cnt_q;
    if (load_any) begin
      cnt_d = '0;
    end else if (do_shift && (cnt_q != CW'(CntMax))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CW'(CntMax);
    else        cnt_q <= cnt_d;
  end

  assign drained = (cnt_q == CW'(CntMax));

  for (genvar r = 0; r < int'(DIM); r++) begin : g_row
    skew_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .DELAY   (r)
    ) u_row (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (row_load[r]),
      .shift (do_shift),
      .din   (Ain),
      .dout  (Aout[r])
    );
  end

endmodule

// File: tb/tb_a_skew_buffer.sv
// Directed and randomized checks of a_skew_buffer at DIM=4, BITS_AB=8.
module tb_a_skew_buffer;

  localparam int DIM = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              WrEn = 1'b0;
  logic [1:0]        Arow = '0;
  logic signed [7:0] Ain  [DIM];
  logic signed [7:0] Aout [DIM];
  logic              drained;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] a_m [DIM][DIM];

  always #5 clk = ~clk;

  a_skew_buffer #(
    .BITS_AB (8),
    .DIM     (DIM)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .WrEn    (WrEn),
    .Arow    (Arow),
    .Ain     (Ain),
    .Aout    (Aout),
    .drained (drained)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected Aout[r] after k shifts of a fully loaded matrix a_m.
  function automatic logic signed [7:0] model(int r, int k);
    if (k - r >= 0 && k - r < DIM) return a_m[r][k - r];
    return 8'sd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(int r, logic e);
    WrEn = 1'b1;
    Arow = 2'(r);
    en   = e;
    for (int c = 0; c < DIM; c++) Ain[c] = a_m[r][c];
    cyc();
    WrEn = 1'b0;
    en   = 1'b0;
  endtask

  task automatic shift1();
    en = 1'b1;
    cyc();
    en = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a_m[r][c] = 8'(16 * r + c + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int r = 0; r < DIM; r++) begin
      checks++;
      if (Aout[r] !== 8'sd0) begin
        errors++;
        $display("FAIL reset_aout[%0d]: got %0d expected 0", r, Aout[r]);
      end
    end
    checks++;
    if (drained !== 1'b1) begin
      errors++;
      $display("FAIL reset_drained: got %b expected 1", drained);
    end
    for (int i = 0; i < 10; i++) begin
      shift1();
      for (int r = 0; r < DIM; r++) begin
        checks++;
        if (Aout[r] !== 8'sd0) begin
          errors++;
          $display("FAIL reset_en%0d_aout[%0d]: got %0d expected 0", i, r, Aout[r]);
        end
      end
    end
  endtask

  task automatic test_skew();
    fill_pattern();
    for (int r = 0; r < DIM; r++) load_row(r, 1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < DIM; r++) begin
        checks++;
        if (Aout[r] !== model(r, k)) begin
          errors++;
          $display("FAIL skew_k%0d_aout[%0d]: got %0d expected %0d", k, r, Aout[r], model(r, k));
        end
      end
      checks++;
      if (drained !== (k == 7)) begin
        errors++;
        $display("FAIL skew_k%0d_drained: got %b expected %b", k, drained, (k == 7));
      end
      if (k < 7) shift1();
    end
  endtask

  task automatic test_signed();
    logic signed [7:0] exp_seq [7];
    exp_seq = '{8'sd0, 8'sd0, -8'sd128, 8'sd127, -8'sd1, 8'sd0, 8'sd0};
    a_m[2][0] = -8'sd128;
    a_m[2][1] = 8'sd127;
    a_m[2][2] = -8'sd1;
    a_m[2][3] = 8'sd0;
    load_row(2, 1'b0);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (Aout[2] !== exp_seq[k]) begin
        errors++;
        $display("FAIL signed_k%0d_aout[2]: got %0d expected %0d", k, Aout[2], exp_seq[k]);
      end
      if (k < 6) shift1();
    end
  endtask

  task automatic test_collision();
    a_m[0][0] = 8'sd9;  a_m[0][1] = 8'sd10; a_m[0][2] = 8'sd11; a_m[0][3] = 8'sd12;
    load_row(0, 1'b0);
    shift1();
    checks++;
    if (Aout[0] !== 8'sd10) begin
      errors++;
      $display("FAIL coll_pre_aout[0]: got %0d expected 10", Aout[0]);
    end
    a_m[1][0] = 8'sd5;  a_m[1][1] = 8'sd6;  a_m[1][2] = 8'sd7;  a_m[1][3] = 8'sd8;
    load_row(1, 1'b1);
    checks++;
    if (Aout[0] !== 8'sd10) begin
      errors++;
      $display("FAIL coll_noshift_aout[0]: got %0d expected 10", Aout[0]);
    end
    checks++;
    if (Aout[1] !== 8'sd0) begin
      errors++;
      $display("FAIL coll_aout[1]: got %0d expected 0", Aout[1]);
    end
    checks++;
    if (drained !== 1'b0) begin
      errors++;
      $display("FAIL coll_drained: got %b expected 0", drained);
    end
    shift1();
    checks++;
    if (Aout[0] !== 8'sd11 || Aout[1] !== 8'sd5) begin
      errors++;
      $display("FAIL coll_shift: got %0d,%0d expected 11,5", Aout[0], Aout[1]);
    end
    for (int i = 0; i < 5; i++) shift1();
    checks++;
    if (drained !== 1'b0) begin
      errors++;
      $display("FAIL coll_cnt6_drained: got %b expected 0", drained);
    end
    shift1();
    checks++;
    if (drained !== 1'b1) begin
      errors++;
      $display("FAIL coll_cnt7_drained: got %b expected 1", drained);
    end
  endtask

  task automatic test_midstream();
    fill_pattern();
    for (int r = 0; r < DIM; r++) load_row(r, 1'b0);
    for (int i = 0; i < 3; i++) shift1();
    checks++;
    if (Aout[3] !== 8'sd49) begin
      errors++;
      $display("FAIL mid_k3_aout[3]: got %0d expected 49", Aout[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int r = 0; r < DIM; r++) begin
      checks++;
      if (Aout[r] !== 8'sd0) begin
        errors++;
        $display("FAIL mid_rst_aout[%0d]: got %0d expected 0", r, Aout[r]);
      end
    end
    checks++;
    if (drained !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_drained: got %b expected 1", drained);
    end
    #2 rst_n = 1'b1;
    cyc();

    fill_pattern();
    for (int r = 0; r < DIM; r++) load_row(r, 1'b0);
    shift1();
    shift1();
    a_m[0][0] = -8'sd5; a_m[0][1] = -8'sd6; a_m[0][2] = -8'sd7; a_m[0][3] = -8'sd8;
    load_row(0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      for (int r = 0; r < DIM; r++) begin
        logic signed [7:0] e;
        e = (r == 0) ? ((j < DIM) ? a_m[0][j] : 8'sd0) : model(r, 2 + j);
        checks++;
        if (Aout[r] !== e) begin
          errors++;
          $display("FAIL reload_j%0d_aout[%0d]: got %0d expected %0d", j, r, Aout[r], e);
        end
      end
      checks++;
      if (drained !== 1'b0) begin
        errors++;
        $display("FAIL reload_j%0d_drained: got %b expected 0", j, drained);
      end
      shift1();
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 100; m++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) a_m[r][c] = 8'($urandom_range(0, 255));
      // en may accompany a load; the load wins and no row moves.
      for (int r = 0; r < DIM; r++) load_row(r, 1'($urandom_range(0, 1)));
      for (int k = 0; k <= 8; k++) begin
        int gap;
        gap = (k == 8) ? 0 : $urandom_range(0, 2);
        for (int g = 0; g <= gap; g++) begin
          logic ok;
          ok = 1'b1;
          for (int r = 0; r < DIM; r++) if (Aout[r] !== model(r, k)) ok = 1'b0;
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL rand_m%0d_k%0d_aout: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                     m, k, Aout[0], Aout[1], Aout[2], Aout[3],
                     model(0, k), model(1, k), model(2, k), model(3, k));
          end
          checks++;
          if (drained !== (k >= 7)) begin
            errors++;
            $display("FAIL rand_m%0d_k%0d_drained: got %b expected %b", m, k, drained, (k >= 7));
          end
          if (g < gap) cyc();
        end
        if (k < 8) shift1();
      end
    end
  endtask

  initial begin
    for (int c = 0; c < DIM; c++) Ain[c] = 8'sd0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a_m[r][c] = 8'sd0;
    test_reset();
    test_skew();
    test_signed();
    test_collision();
    test_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
